// File: rtl/dkong_obj_dma_pkg.sv
// Shared types and constants for the object-RAM DMA sequencer.
package dkong_obj_dma_pkg;

    localparam int LEN_W = 14;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } dma_state_t;

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;

endpackage

// File: rtl/dkong_obj_dma_regs.sv
// DMA programming registers: falling-edge write capture, locked while busy,
// and the post-transfer length clear requested by the parent.
module dkong_obj_dma_regs
    import dkong_obj_dma_pkg::*;
#(
    parameter logic [15:0]      SRC_DEFAULT = 16'h6900,
    parameter logic [15:0]      DST_DEFAULT = 16'h7000,
    parameter logic [LEN_W-1:0] LEN_DEFAULT = 14'd384
) (
    input  logic             I_CLK24M,
    input  logic             I_RESET,
    input  logic             I_CFG_WR_n,
    input  logic [2:0]       I_CFG_A,
    input  logic [7:0]       I_CFG_DB,
    input  logic             busy,
    input  logic             len_clr,
    output logic [15:0]      src,
    output logic [15:0]      dst,
    output logic [LEN_W-1:0] len
);

    logic wr_n_q;
    logic wr_stb;

    assign wr_stb = !I_CFG_WR_n && wr_n_q && !busy;

    always_ff @(posedge I_CLK24M) begin
        if (I_RESET) begin
            wr_n_q <= 1'b1;
            src    <= SRC_DEFAULT;
            dst    <= DST_DEFAULT;
            len    <= LEN_DEFAULT;
        end else begin
            wr_n_q <= I_CFG_WR_n;
            if (wr_stb) begin
                case (I_CFG_A)
                    REG_SRC_LO: src[7:0]       <= I_CFG_DB;
                    REG_SRC_HI: src[15:8]      <= I_CFG_DB;
                    REG_DST_LO: dst[7:0]       <= I_CFG_DB;
                    REG_DST_HI: dst[15:8]      <= I_CFG_DB;
                    REG_LEN_LO: len[7:0]       <= I_CFG_DB;
                    REG_LEN_HI: len[LEN_W-1:8] <= I_CFG_DB[LEN_W-9:0];
                    default: ;
                endcase
            end
            // only asserted in DONE, when writes are already locked out
            if (len_clr)
                len <= '0;
        end
    end

endmodule

// File: rtl/dkong_obj_dma.sv
// Sprite DMA: copies a work-RAM block into object RAM under BUSRQ/BUSAK.
// Build option DKONG_OBJ_DMA_AUTOINIT_EN keeps the length programmed after DONE.
//
//  state | meaning
//  IDLE  | bus released, waiting for a pending trigger on a tick
//  REQ   | BUSRQ_n low, waiting for BUSAK_n (also re-entered after losing the bus)
//  RD    | source address out, MEMRD_n low for one tick period
//  WR    | destination address out, OBJ_WR_n low for one tick period
//  DONE  | bus released, TC pulsed, back to IDLE on next tick
module dkong_obj_dma
    import dkong_obj_dma_pkg::*;
#(
    parameter logic [15:0]      SRC_DEFAULT = 16'h6900,
    parameter logic [15:0]      DST_DEFAULT = 16'h7000,
    parameter logic [LEN_W-1:0] LEN_DEFAULT = 14'd384
) (
    input  logic        I_CLK24M,
    input  logic        I_RESET,
    input  logic        I_CLK_EN_P,
    input  logic        I_DRQ,
    input  logic        I_CFG_WR_n,
    input  logic [2:0]  I_CFG_A,
    input  logic [7:0]  I_CFG_DB,
    input  logic        I_BUSAK_n,
    input  logic [7:0]  I_DB,
    output logic        O_BUSRQ_n,
    output logic [15:0] O_AB,
    output logic [7:0]  O_DB,
    output logic        O_MEMRD_n,
    output logic        O_OBJ_WR_n,
    output logic        O_BUSY,
    output logic        O_TC
);

    dma_state_t       state;
    logic             drq_q;
    logic             pending;
    logic [15:0]      work_src;
    logic [15:0]      work_dst;
    logic [LEN_W-1:0] work_len;
    logic [15:0]      reg_src;
    logic [15:0]      reg_dst;
    logic [LEN_W-1:0] reg_len;
    logic             len_clr;

`ifdef DKONG_OBJ_DMA_AUTOINIT_EN
    assign len_clr = 1'b0;
`else
    assign len_clr = O_TC;
`endif

    dkong_obj_dma_regs #(
        .SRC_DEFAULT (SRC_DEFAULT),
        .DST_DEFAULT (DST_DEFAULT),
        .LEN_DEFAULT (LEN_DEFAULT)
    ) u_regs (
        .I_CLK24M   (I_CLK24M),
        .I_RESET    (I_RESET),
        .I_CFG_WR_n (I_CFG_WR_n),
        .I_CFG_A    (I_CFG_A),
        .I_CFG_DB   (I_CFG_DB),
        .busy       (O_BUSY),
        .len_clr    (len_clr),
        .src        (reg_src),
        .dst        (reg_dst),
        .len        (reg_len)
    );

    always_ff @(posedge I_CLK24M) begin
        if (I_RESET) begin
            state      <= IDLE;
            drq_q      <= 1'b0;
            pending    <= 1'b0;
            work_src   <= '0;
            work_dst   <= '0;
            work_len   <= '0;
            O_BUSRQ_n  <= 1'b1;
            O_AB       <= '0;
            O_DB       <= '0;
            O_MEMRD_n  <= 1'b1;
            O_OBJ_WR_n <= 1'b1;
            O_BUSY     <= 1'b0;
            O_TC       <= 1'b0;
        end else begin
            drq_q <= I_DRQ;
            O_TC  <= 1'b0;
            if (I_DRQ && !drq_q && !O_BUSY)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (I_CLK_EN_P && pending) begin
                        pending   <= 1'b0;
                        work_src  <= reg_src;
                        work_dst  <= reg_dst;
                        work_len  <= reg_len;
                        O_BUSY    <= 1'b1;
                        O_BUSRQ_n <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (I_CLK_EN_P && !I_BUSAK_n) begin
                        if (work_len == '0) begin
                            O_BUSRQ_n <= 1'b1;
                            O_TC      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            O_AB      <= work_src;
                            O_MEMRD_n <= 1'b0;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    // losing the bus parks in REQ; the byte restarts from RD
                    if (I_BUSAK_n) begin
                        O_MEMRD_n <= 1'b1;
                        state     <= REQ;
                    end else if (I_CLK_EN_P) begin
                        O_DB       <= I_DB;
                        O_AB       <= work_dst;
                        O_MEMRD_n  <= 1'b1;
                        O_OBJ_WR_n <= 1'b0;
                        state      <= WR;
                    end
                end
                WR: begin
                    if (I_BUSAK_n) begin
                        O_OBJ_WR_n <= 1'b1;
                        state      <= REQ;
                    end else if (I_CLK_EN_P) begin
                        O_OBJ_WR_n <= 1'b1;
                        work_src   <= work_src + 16'd1;
                        work_dst   <= work_dst + 16'd1;
                        work_len   <= work_len - LEN_ONE;
                        if (work_len == LEN_ONE) begin
                            O_BUSRQ_n <= 1'b1;
                            O_TC      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            O_AB      <= work_src + 16'd1;
                            O_MEMRD_n <= 1'b0;
                            state     <= RD;
                        end
                    end
                end
                DONE: begin
                    if (I_CLK_EN_P) begin
                        O_BUSY <= 1'b0;
                        O_AB   <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dkong_obj_dma.sv
// Directed bench for dkong_obj_dma: source memory model, strobe monitor, logs.
module tb_dkong_obj_dma;
    import dkong_obj_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen = 1'b0;
    logic        drq;
    logic        cfg_wr_n;
    logic [2:0]  cfg_a;
    logic [7:0]  cfg_db;
    logic        busak_n;
    logic [7:0]  db_in;
    logic        busrq_n;
    logic [15:0] ab;
    logic [7:0]  db_out;
    logic        memrd_n;
    logic        objwr_n;
    logic        busy;
    logic        tc;

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign db_in = src_byte(ab);

    dkong_obj_dma dut (
        .I_CLK24M   (clk),
        .I_RESET    (rst),
        .I_CLK_EN_P (cen),
        .I_DRQ      (drq),
        .I_CFG_WR_n (cfg_wr_n),
        .I_CFG_A    (cfg_a),
        .I_CFG_DB   (cfg_db),
        .I_BUSAK_n  (busak_n),
        .I_DB       (db_in),
        .O_BUSRQ_n  (busrq_n),
        .O_AB       (ab),
        .O_DB       (db_out),
        .O_MEMRD_n  (memrd_n),
        .O_OBJ_WR_n (objwr_n),
        .O_BUSY     (busy),
        .O_TC       (tc)
    );

    always #20 clk = ~clk;

    logic [2:0] tick_div = 3'd0;
    always @(negedge clk) begin
        tick_div = tick_div + 3'd1;
        cen = (tick_div == 3'd0);
    end

    // strobe monitor: logs addresses/data on each strobe falling edge
    logic        mon_en = 1'b0;
    logic        memrd_q = 1'b1;
    logic        objwr_q = 1'b1;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          tc_cnt = 0;
    int          req_ticks = 0;
    logic [15:0] rd_addr [4096];
    logic [15:0] wr_addr [4096];
    logic [7:0]  wr_data [4096];

    always @(negedge clk) begin
        if (mon_en) begin
            if (!memrd_n && memrd_q) begin
                if (rd_cnt < 4096) rd_addr[rd_cnt] = ab;
                rd_cnt = rd_cnt + 1;
            end
            if (!objwr_n && objwr_q) begin
                if (wr_cnt < 4096) begin
                    wr_addr[wr_cnt] = ab;
                    wr_data[wr_cnt] = db_out;
                end
                wr_cnt = wr_cnt + 1;
            end
            if (tc) tc_cnt = tc_cnt + 1;
        end
        memrd_q = memrd_n;
        objwr_q = objwr_n;
    end

    always @(posedge clk)
        if (cen && !busrq_n) req_ticks = req_ticks + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // counts write-log entries that disagree with a contiguous src->dst copy
    function automatic int image_errs(input int w0, input logic [15:0] s,
                                      input logic [15:0] d, input int n);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            logic [15:0] sa = s + 16'(k);
            logic [15:0] da = d + 16'(k);
            if (w0 + k >= 4096) e++;
            else if (wr_addr[w0+k] !== da || wr_data[w0+k] !== src_byte(sa)) e++;
        end
        return e;
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_a = a; cfg_db = d; cfg_wr_n = 1'b0;
        @(negedge clk);
        cfg_wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic trigger();
        @(negedge clk); drq = 1'b0;
        @(negedge clk); drq = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (busrq_n && n < 200) begin @(negedge clk); n++; end
        chk(tag, busrq_n, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 8000) begin @(negedge clk); n++; end
        chk(tag, busy, 1'b0);
    endtask

    task automatic run_xfer(input string tag);
        trigger();
        wait_req({tag, "_req"});
        busak_n = 1'b0;
        wait_idle({tag, "_done"});
        busak_n = 1'b1;
    endtask

    int r0, w0, t0, q0, rs, ws, n;

    initial begin
        rst = 1'b1; drq = 1'b0; cfg_wr_n = 1'b1; cfg_a = '0; cfg_db = '0; busak_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_busrq_n", busrq_n, 1'b1);
        chk("rst_memrd_n", memrd_n, 1'b1);
        chk("rst_objwr_n", objwr_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tc", tc, 1'b0);
        chk("rst_ab", ab, 16'h0000);
        chk("rst_db", db_out, 8'h00);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // default block, ack three ticks after the request
        r0 = rd_cnt; w0 = wr_cnt; t0 = tc_cnt; q0 = req_ticks;
        trigger();
        wait_req("a_req");
        n = 0;
        while (req_ticks - q0 < 2 && n < 100) begin @(negedge clk); n++; end
        busak_n = 1'b0;
        wait_idle("a_done");
        busak_n = 1'b1;
        chk("a_rd_count", rd_cnt - r0, 384);
        chk("a_wr_count", wr_cnt - w0, 384);
        chk("a_tc_count", tc_cnt - t0, 1);
        chk("a_req_ticks", req_ticks - q0, 771);
        chk("a_first_rd", rd_addr[r0], 16'h6900);
        chk("a_last_rd", rd_addr[r0+383], 16'h6A7F);
        chk("a_image", image_errs(w0, 16'h6900, 16'h7000, 384), 0);

        // retrigger without reprogramming
        r0 = rd_cnt; w0 = wr_cnt; t0 = tc_cnt;
        run_xfer("f");
`ifdef DKONG_OBJ_DMA_AUTOINIT_EN
        chk("f_rd_count", rd_cnt - r0, 384);
        chk("f_wr_count", wr_cnt - w0, 384);
        chk("f_image", image_errs(w0, 16'h6900, 16'h7000, 384), 0);
`else
        chk("f_rd_count", rd_cnt - r0, 0);
        chk("f_wr_count", wr_cnt - w0, 0);
`endif
        chk("f_tc_count", tc_cnt - t0, 1);

        // programmed 3-byte copy from 1234H
        cfg_write(REG_SRC_LO, 8'h34);
        cfg_write(REG_SRC_HI, 8'h12);
        cfg_write(REG_LEN_LO, 8'h03);
        cfg_write(REG_LEN_HI, 8'h00);
        r0 = rd_cnt; w0 = wr_cnt; t0 = tc_cnt;
        run_xfer("b");
        chk("b_rd_count", rd_cnt - r0, 3);
        chk("b_wr_count", wr_cnt - w0, 3);
        chk("b_ab0", rd_addr[r0],   16'h1234);
        chk("b_ab1", wr_addr[w0],   16'h7000);
        chk("b_ab2", rd_addr[r0+1], 16'h1235);
        chk("b_ab3", wr_addr[w0+1], 16'h7001);
        chk("b_ab4", rd_addr[r0+2], 16'h1236);
        chk("b_ab5", wr_addr[w0+2], 16'h7002);
        chk("b_db0", wr_data[w0], src_byte(16'h1234));
        chk("b_image", image_errs(w0, 16'h1234, 16'h7000, 3), 0);
        chk("b_tc_count", tc_cnt - t0, 1);

        // bus lost for 5 ticks during the read of byte 10
        cfg_write(REG_SRC_LO, 8'h00);
        cfg_write(REG_SRC_HI, 8'h20);
        cfg_write(REG_LEN_LO, 8'h10);
        r0 = rd_cnt; w0 = wr_cnt;
        trigger();
        wait_req("c_req");
        busak_n = 1'b0;
        n = 0;
        while (rd_cnt - r0 < 11 && n < 2000) begin @(negedge clk); n++; end
        chk("c_reach_byte10", rd_cnt - r0, 11);
        busak_n = 1'b1;
        @(negedge clk);
        chk("c_gap_memrd_n", memrd_n, 1'b1);
        chk("c_gap_objwr_n", objwr_n, 1'b1);
        rs = rd_cnt; ws = wr_cnt; q0 = req_ticks;
        n = 0;
        while (req_ticks - q0 < 5 && n < 200) begin @(negedge clk); n++; end
        chk("c_gap_rd", rd_cnt, rs);
        chk("c_gap_wr", wr_cnt, ws);
        busak_n = 1'b0;
        wait_idle("c_done");
        busak_n = 1'b1;
        chk("c_rd_count", rd_cnt - r0, 17);
        chk("c_wr_count", wr_cnt - w0, 16);
        chk("c_redo_addr", rd_addr[r0+11], 16'h200A);
        chk("c_image", image_errs(w0, 16'h2000, 16'h7000, 16), 0);

        // DRQ edge and register write while busy are both dropped
        cfg_write(REG_SRC_LO, 8'h00);
        cfg_write(REG_SRC_HI, 8'h30);
        cfg_write(REG_LEN_LO, 8'h04);
        r0 = rd_cnt; w0 = wr_cnt; t0 = tc_cnt;
        trigger();
        wait_req("d_req");
        busak_n = 1'b0;
        n = 0;
        while (rd_cnt - r0 < 1 && n < 200) begin @(negedge clk); n++; end
        drq = 1'b0;
        @(negedge clk);
        drq = 1'b1;
        cfg_write(REG_SRC_LO, 8'h77);
        wait_idle("d_done");
        busak_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("d_wr_count", wr_cnt - w0, 4);
        chk("d_tc_count", tc_cnt - t0, 1);
        chk("d_no_retrig", busy, 1'b0);
        cfg_write(REG_LEN_LO, 8'h01);
        r0 = rd_cnt;
        run_xfer("d2");
        chk("d_src_kept", rd_addr[r0], 16'h3000);

        // reset during the write of byte 2
        cfg_write(REG_SRC_HI, 8'h50);
        cfg_write(REG_DST_LO, 8'h40);
        cfg_write(REG_LEN_LO, 8'h0A);
        w0 = wr_cnt;
        trigger();
        wait_req("e_req");
        busak_n = 1'b0;
        n = 0;
        while (wr_cnt - w0 < 3 && n < 2000) begin @(negedge clk); n++; end
        chk("e_reach_byte2", wr_cnt - w0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("e_busrq_n", busrq_n, 1'b1);
        chk("e_busy", busy, 1'b0);
        chk("e_memrd_n", memrd_n, 1'b1);
        chk("e_objwr_n", objwr_n, 1'b1);
        chk("e_ab", ab, 16'h0000);
        rst = 1'b0;
        busak_n = 1'b1;
        repeat (2) @(negedge clk);
        r0 = rd_cnt; w0 = wr_cnt;
        run_xfer("e2");
        chk("e_def_rd", rd_addr[r0], 16'h6900);
        chk("e_def_wr_count", wr_cnt - w0, 384);
        chk("e_def_image", image_errs(w0, 16'h6900, 16'h7000, 384), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #8000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
